retire_trace_buffer: RTL and testbench
======================================

RETIRE_TRACE_BUFFER -- requirements
Module: retire_trace_buffer

Interface
REQ-001 SHALL have parameter XLEN, default 32: width of PC and write-back data.
REQ-002 SHALL have parameter DEPTH, default 16: trace entries; power of two, at least 4.
REQ-003 SHALL have parameter TS_W, default 16: timestamp width.
REQ-004 SHALL have the following ports (CW = $clog2(DEPTH)+1):
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- arm  in  1  pulse; starts a capture session.
- abort  in  1  pulse; ends capture early.
- mode_wrap  in  1  1 = circular history; 0 = stop-when-full. Sampled at arm.
- trig_en  in  1  1 = wait for PC trigger. Sampled at arm.
- trig_pc  in  XLEN  trigger PC. Sampled at arm.
- post_count  in  CW  entries to record from the trigger onward; 0 means DEPTH. Sampled at arm.
- wb_enable  in  1  retire event valid.
- wb_pc  in  XLEN  retire event PC.
- wb_rd  in  5  retire event destination register.
- wb_data  in  XLEN  retire event write-back data.
- rd_en  in  1  pop the oldest entry.
- rd_valid  out  1  read data valid.
- rd_pc  out  XLEN  popped entry PC.
- rd_rd  out  5  popped entry destination register.
- rd_data  out  XLEN  popped entry data.
- rd_ts  out  TS_W  popped entry timestamp.
- state  out  2  current state.
- count  out  CW  entries held.
- overflow  out  1  sticky; an entry was overwritten.
- done  out  1  high in DONE.

Function
REQ-005 SHALL implement states IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
REQ-006 IDLE or DONE with arm=1 SHALL clear count, pointers, overflow and timestamp, then go to ARMED if trig_en=1, else CAPTURE.
REQ-007 arm SHALL be ignored in ARMED and CAPTURE.
REQ-008 abort SHALL move ARMED or CAPTURE to DONE next cycle, keeping buffer contents; abort SHALL take priority over a simultaneous trigger or stop condition.
REQ-009 A "record" SHALL write {wb_pc, wb_rd, wb_data, ts} at the write pointer on the same edge that wb_enable=1, increment count, and advance the write pointer modulo DEPTH.
REQ-010 ARMED with mode_wrap=1 SHALL record every retire event as pre-trigger history; ARMED with mode_wrap=0 SHALL record nothing.
REQ-011 Trigger SHALL be wb_enable=1 with wb_pc==trig_pc in ARMED; the triggering event SHALL be recorded, and the state SHALL go to CAPTURE next cycle.
REQ-012 CAPTURE SHALL record every retire event.
REQ-013 With mode_wrap=0, the state SHALL go to DONE on the edge that count reaches DEPTH; later events SHALL be dropped.
REQ-014 With mode_wrap=1, the block SHALL go to DONE once post_count events (0 means DEPTH) have been recorded since the trigger, trigger event included.
REQ-015 With trig_en=0, counting for REQ-014 SHALL start at the first CAPTURE event.
REQ-016 Recording while count==DEPTH (wrap mode) SHALL overwrite the oldest entry, advance the read pointer, hold count at DEPTH, and set overflow.
REQ-017 ts SHALL be a TS_W-bit cycle counter cleared by arm, incrementing every cycle in ARMED and CAPTURE, wrapping modulo 2^TS_W.
REQ-018 rd_en in DONE with count>0 SHALL read the oldest entry; rd_valid and rd_* SHALL be valid exactly one cycle later, with count decremented on the rd_en edge.
REQ-019 rd_en with count==0, or outside DONE, SHALL be ignored and rd_valid SHALL stay 0.
REQ-020 rd_* SHALL hold their last value when rd_valid=0.

Reset
REQ-021 rst_n low SHALL asynchronously force state=IDLE, with all pointers, count, ts, overflow, rd_valid and rd_* at 0, and done=0.
REQ-022 Reset mid-capture or mid-read SHALL discard the session; RAM contents need not be cleared.

Structure
REQ-023 State encoding, the entry-field widths and the entry pack width SHALL live in shared package riscv_trace_pkg.
REQ-024 Storage SHALL be one sub-module, trace_ram: simple dual-port, one write port, one registered read port, DEPTH x (2*XLEN+5+TS_W).

Verification
REQ-025 Stop mode, no trigger: arm, then retire 20 events with PCs 0x00..0x4C → DONE after event 16, count=16, overflow=0; 16 pops return PCs 0x00..0x3C in order.
REQ-026 Wrap mode, trigger 0x40, post_count=4: retire PCs 0x00,0x04,..,0x80 → DONE after PC 0x4C; pops return PCs 0x10..0x4C (16 entries), overflow=1.
REQ-027 Abort in ARMED after 3 pre-trigger events (wrap mode) → DONE, count=3, pops return those 3 entries; the 4th rd_en gives rd_valid=0.
REQ-028 Simultaneous abort and trigger event → DONE, with the trigger event recorded.
REQ-029 TS_W=4 with 20 idle cycles before the first event → the entry's rd_ts equals (cycles since arm) mod 16.
REQ-030 rst_n low for one cycle in CAPTURE → state=0, count=0, done=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/riscv_trace_pkg.sv
// Shared definitions for the retire trace buffer: state encoding and entry layout.
package riscv_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } trace_state_t;

  localparam int RD_W = 5;

  // Entry packs {pc, rd, data, ts} with pc in the most significant bits.
  function automatic int entry_width(input int xlen, input int ts_w);
    return 2 * xlen + RD_W + ts_w;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: one write port, one registered read port.
module trace_ram
  import riscv_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = entry_width(32, 16)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register holds its last value between reads so the popped entry stays visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/retire_trace_buffer.sv
// Captures retired instructions into a trace RAM around an optional PC trigger,
// then lets software drain the captured history oldest-first.
module retire_trace_buffer
  import riscv_trace_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int TS_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   arm,
  input  logic                   abort,
  input  logic                   mode_wrap,
  input  logic                   trig_en,
  input  logic [XLEN-1:0]        trig_pc,
  input  logic [$clog2(DEPTH):0] post_count,
  input  logic                   wb_enable,
  input  logic [XLEN-1:0]        wb_pc,
  input  logic [4:0]             wb_rd,
  input  logic [XLEN-1:0]        wb_data,
  input  logic                   rd_en,
  output logic                   rd_valid,
  output logic [XLEN-1:0]        rd_pc,
  output logic [4:0]             rd_rd,
  output logic [XLEN-1:0]        rd_data,
  output logic [TS_W-1:0]        rd_ts,
  output logic [1:0]             state,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = entry_width(XLEN, TS_W);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] ONE  = CW'(1);

  trace_state_t    state_q;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count_q, post_target, post_seen, post_next;
  logic            overflow_q, wrap_q, rd_valid_q;
  logic [TS_W-1:0] ts_q;
  logic [XLEN-1:0] trig_pc_q;
  logic            trig_hit, do_rec, counted, finish, do_read, at_full;
  logic [EW-1:0]   wr_entry, rd_entry;

  always_comb begin
    trig_hit  = (state_q == ST_ARMED) && wb_enable && (wb_pc == trig_pc_q);
    at_full   = (count_q == FULL);
    do_rec    = 1'b0;
    case (state_q)
      ST_ARMED:   do_rec = wrap_q ? wb_enable : trig_hit;
      ST_CAPTURE: do_rec = wb_enable && (wrap_q || !at_full);
      default:    do_rec = 1'b0;
    endcase
    // Post-trigger counting covers the trigger itself and every capture-phase record.
    counted   = do_rec && ((state_q == ST_CAPTURE) || trig_hit);
    post_next = post_seen + ONE;
    finish    = do_rec && (wrap_q ? (counted && (post_next == post_target))
                                  : (count_q == FULL - ONE));
    do_read   = (state_q == ST_DONE) && rd_en && !arm && (count_q != '0);
  end

  assign wr_entry = {wb_pc, wb_rd, wb_data, ts_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      post_target <= '0;
      post_seen   <= '0;
      overflow_q  <= 1'b0;
      wrap_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      ts_q        <= '0;
      trig_pc_q   <= '0;
    end else begin
      rd_valid_q <= do_read;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            post_seen   <= '0;
            overflow_q  <= 1'b0;
            ts_q        <= '0;
            wrap_q      <= mode_wrap;
            trig_pc_q   <= trig_pc;
            post_target <= (post_count == '0) ? FULL : post_count;
            state_q     <= trig_en ? ST_ARMED : ST_CAPTURE;
          end else if (do_read) begin
            rd_ptr  <= rd_ptr + AW'(1);
            count_q <= count_q - ONE;
          end
        end
        default: begin
          ts_q <= ts_q + TS_W'(1);
          if (do_rec) begin
            wr_ptr <= wr_ptr + AW'(1);
            // A full wrap-mode buffer drops its oldest entry to make room.
            if (at_full) begin
              rd_ptr     <= rd_ptr + AW'(1);
              overflow_q <= 1'b1;
            end else begin
              count_q <= count_q + ONE;
            end
          end
          if (counted) post_seen <= post_next;
          if (abort || finish) state_q <= ST_DONE;
          else if (trig_hit)   state_q <= ST_CAPTURE;
        end
      endcase
    end
  end

  trace_ram #(
    .DEPTH(DEPTH),
    .WIDTH(EW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (do_rec),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .re    (do_read),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  assign rd_pc    = rd_entry[EW-1 -: XLEN];
  assign rd_rd    = rd_entry[TS_W+XLEN +: RD_W];
  assign rd_data  = rd_entry[TS_W +: XLEN];
  assign rd_ts    = rd_entry[TS_W-1:0];
  assign rd_valid = rd_valid_q;
  assign state    = state_q;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Randomized and directed bench for retire_trace_buffer against a queue-based model.
module tb_retire_trace_buffer;

  localparam int XLEN  = 32;
  localparam int DEPTH = 16;
  localparam int TS_W  = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            arm, abort, mode_wrap, trig_en, wb_enable, rd_en;
  logic [XLEN-1:0] trig_pc, wb_pc, wb_data;
  logic [CW-1:0]   post_count;
  logic [4:0]      wb_rd;
  logic            rd_valid, overflow, done;
  logic [XLEN-1:0] rd_pc, rd_data;
  logic [4:0]      rd_rd;
  logic [TS_W-1:0] rd_ts;
  logic [1:0]      state;
  logic [CW-1:0]   count;

  int n_checks = 0;
  int n_fail   = 0;

  retire_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .mode_wrap(mode_wrap),
    .trig_en(trig_en), .trig_pc(trig_pc), .post_count(post_count),
    .wb_enable(wb_enable), .wb_pc(wb_pc), .wb_rd(wb_rd), .wb_data(wb_data),
    .rd_en(rd_en), .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_rd(rd_rd),
    .rd_data(rd_data), .rd_ts(rd_ts), .state(state), .count(count),
    .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the trace is a plain queue, oldest entry at the front.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    logic [TS_W-1:0] ts;
  } entry_t;

  entry_t          mq[$];
  entry_t          m_rd = '0;
  entry_t          m_new;
  int              m_state = 0;
  int              m_target = 0;
  int              m_seen = 0;
  bit              m_ovf = 0, m_rdv = 0, m_wrap = 0;
  bit              m_hit, m_rec, m_counted, m_finish;
  logic [TS_W-1:0] m_ts = '0;
  logic [XLEN-1:0] m_tpc = '0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_state = 0; mq.delete(); m_ovf = 0; m_ts = '0; m_rdv = 0; m_rd = '0; m_seen = 0;
    end else if (m_state == 0 || m_state == 3) begin
      m_rdv = 0;
      if (arm) begin
        mq.delete(); m_ovf = 0; m_ts = '0; m_seen = 0;
        m_wrap = mode_wrap; m_tpc = trig_pc;
        m_target = (post_count == '0) ? DEPTH : int'(post_count);
        m_state = trig_en ? 1 : 2;
      end else if (m_state == 3 && rd_en && mq.size() > 0) begin
        m_rd = mq.pop_front();
        m_rdv = 1;
      end
    end else begin
      m_rdv = 0;
      m_hit = (m_state == 1) && wb_enable && (wb_pc == m_tpc);
      if (m_state == 1) m_rec = wb_enable && (m_wrap || m_hit);
      else              m_rec = wb_enable && (m_wrap || mq.size() < DEPTH);
      if (m_rec) begin
        m_new = '{pc: wb_pc, rd: wb_rd, data: wb_data, ts: m_ts};
        mq.push_back(m_new);
        if (mq.size() > DEPTH) begin
          mq.delete(0);
          m_ovf = 1;
        end
      end
      m_counted = m_rec && (m_state == 2 || m_hit);
      if (m_counted) m_seen++;
      m_finish = m_rec && (m_wrap ? (m_counted && m_seen == m_target) : (mq.size() == DEPTH));
      m_ts = m_ts + TS_W'(1);
      if (abort || m_finish) m_state = 3;
      else if (m_hit)        m_state = 2;
    end
  end

  // Every cycle, away from the active edge, all outputs must match the model.
  initial forever begin
    @(negedge clk);
    check_output("cyc_state",    64'(state),    64'(m_state));
    check_output("cyc_count",    64'(count),    64'(mq.size()));
    check_output("cyc_overflow", 64'(overflow), 64'(m_ovf));
    check_output("cyc_done",     64'(done),     64'(m_state == 3));
    check_output("cyc_rd_valid", 64'(rd_valid), 64'(m_rdv));
    check_output("cyc_rd_pc",    64'(rd_pc),    64'(m_rd.pc));
    check_output("cyc_rd_rd",    64'(rd_rd),    64'(m_rd.rd));
    check_output("cyc_rd_data",  64'(rd_data),  64'(m_rd.data));
    check_output("cyc_rd_ts",    64'(rd_ts),    64'(m_rd.ts));
  end

  logic [XLEN-1:0] popped_pc[$];
  logic [TS_W-1:0] popped_ts[$];
  logic            last_rdv;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic w, input logic t, input logic [XLEN-1:0] p, input int pc);
    arm = 1'b1; mode_wrap = w; trig_en = t; trig_pc = p; post_count = CW'(pc);
    tick();
    arm = 1'b0;
  endtask

  task automatic retire(input logic [XLEN-1:0] pc);
    wb_enable = 1'b1; wb_pc = pc; wb_rd = 5'($urandom); wb_data = $urandom;
    tick();
    wb_enable = 1'b0;
  endtask

  task automatic abort_pulse();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic pop_n(input int n);
    popped_pc.delete();
    popped_ts.delete();
    for (int i = 0; i < n; i++) begin
      rd_en = 1'b1;
      tick();
      if (rd_valid) begin
        popped_pc.push_back(rd_pc);
        popped_ts.push_back(rd_ts);
      end
    end
    last_rdv = rd_valid;
    rd_en = 1'b0;
  endtask

  function automatic logic [63:0] pc_at(input int i);
    return (i < popped_pc.size()) ? 64'(popped_pc[i]) : 64'hDEAD_BEEF_DEAD_BEEF;
  endfunction

  initial begin
    arm = 0; abort = 0; mode_wrap = 0; trig_en = 0; trig_pc = '0; post_count = '0;
    wb_enable = 0; wb_pc = '0; wb_rd = '0; wb_data = '0; rd_en = 0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_output("reset_state", 64'(state), 64'd0);
    check_output("reset_count", 64'(count), 64'd0);
    check_output("reset_done",  64'(done),  64'd0);

    $display("[TB] stop mode, no trigger");
    do_arm(1'b0, 1'b0, '0, 0);
    check_output("stop_after_arm", 64'(state), 64'd2);
    for (int i = 0; i < 20; i++) begin
      retire(XLEN'(i * 4));
      if (i == 14) check_output("stop_before_full", 64'(state), 64'd2);
      if (i == 15) check_output("stop_done_at_16", 64'(state), 64'd3);
    end
    check_output("stop_count", 64'(count), 64'd16);
    check_output("stop_overflow", 64'(overflow), 64'd0);
    pop_n(16);
    check_output("stop_pop_n", 64'(popped_pc.size()), 64'd16);
    for (int i = 0; i < 16; i++) check_output("stop_pop_pc", pc_at(i), 64'(i * 4));

    $display("[TB] wrap mode, trigger 0x40, post_count 4");
    do_arm(1'b1, 1'b1, 32'h40, 4);
    for (int i = 0; i <= 32; i++) begin
      retire(XLEN'(i * 4));
      if (i == 15) check_output("wrap_armed_full", 64'(state), 64'd1);
      if (i == 16) check_output("wrap_trigger", 64'(state), 64'd2);
      if (i == 18) check_output("wrap_still_capture", 64'(state), 64'd2);
      if (i == 19) check_output("wrap_done_at_4c", 64'(state), 64'd3);
    end
    check_output("wrap_count", 64'(count), 64'd16);
    check_output("wrap_overflow", 64'(overflow), 64'd1);
    pop_n(16);
    check_output("wrap_pop_n", 64'(popped_pc.size()), 64'd16);
    for (int i = 0; i < 16; i++) check_output("wrap_pop_pc", pc_at(i), 64'(32'h10 + i * 4));

    $display("[TB] abort in armed");
    do_arm(1'b1, 1'b1, 32'h1000, 0);
    retire(32'h100); retire(32'h104); retire(32'h108);
    check_output("abort_armed_state", 64'(state), 64'd1);
    abort_pulse();
    check_output("abort_done", 64'(state), 64'd3);
    check_output("abort_count", 64'(count), 64'd3);
    pop_n(4);
    check_output("abort_pop_n", 64'(popped_pc.size()), 64'd3);
    for (int i = 0; i < 3; i++) check_output("abort_pop_pc", pc_at(i), 64'(32'h100 + i * 4));
    check_output("abort_4th_rd_valid", 64'(last_rdv), 64'd0);

    $display("[TB] abort together with trigger");
    do_arm(1'b0, 1'b1, 32'h200, 0);
    retire(32'h1FC);
    check_output("abtrig_pre_dropped", 64'(count), 64'd0);
    abort = 1'b1; wb_enable = 1'b1; wb_pc = 32'h200; wb_data = 32'h1234_5678;
    tick();
    abort = 1'b0; wb_enable = 1'b0;
    check_output("abtrig_state", 64'(state), 64'd3);
    check_output("abtrig_count", 64'(count), 64'd1);
    pop_n(1);
    check_output("abtrig_pc", pc_at(0), 64'h200);

    $display("[TB] timestamp wrap after 20 idle cycles");
    do_arm(1'b0, 1'b0, '0, 0);
    repeat (20) tick();
    retire(32'h300);
    abort_pulse();
    pop_n(1);
    check_output("ts_pop_n", 64'(popped_ts.size()), 64'd1);
    check_output("ts_value", (popped_ts.size() > 0) ? 64'(popped_ts[0]) : 64'hFF, 64'd4);

    $display("[TB] asynchronous reset in capture");
    do_arm(1'b1, 1'b0, '0, 0);
    retire(32'h500); retire(32'h504);
    check_output("areset_pre_count", 64'(count), 64'd2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("areset_state", 64'(state), 64'd0);
    check_output("areset_count", 64'(count), 64'd0);
    check_output("areset_done",  64'(done),  64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_output("areset_idle", 64'(state), 64'd0);

    $display("[TB] randomized sessions");
    for (int s = 0; s < 30; s++) begin
      abort_pulse();
      do_arm(1'($urandom), 1'($urandom), XLEN'(4 * $urandom_range(0, 15)), $urandom_range(0, 20));
      for (int c = 0; c < 60; c++) begin
        wb_enable  = ($urandom_range(0, 3) != 0);
        wb_pc      = XLEN'(4 * $urandom_range(0, 15));
        wb_rd      = 5'($urandom);
        wb_data    = $urandom;
        abort      = ($urandom_range(0, 40) == 0);
        arm        = ($urandom_range(0, 15) == 0);
        mode_wrap  = 1'($urandom);
        trig_en    = 1'($urandom);
        trig_pc    = XLEN'(4 * $urandom_range(0, 15));
        post_count = CW'($urandom_range(0, 20));
        rd_en      = 1'($urandom);
        tick();
      end
      arm = 0; abort = 0; wb_enable = 0; rd_en = 0;
      abort_pulse();
      pop_n(DEPTH + 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
